// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared funct3 encodings, FSM states and request record for
//               the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : RV32I byte/halfword/word lane steering for stores and
//               sign/zero extension for loads; flags bad f3 or misalignment.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        bad
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rword[{addr_lo, 3'b000} +: 8];
    assign w_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Store-only legality (f3[2] set) is judged by the caller, which knows the op.
    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        ldata = 32'h0;
        bad   = 1'b0;
        case (f3)
            F3_LB: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
                ldata = {{24{w_byte[7]}}, w_byte};
            end
            F3_LBU: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
                ldata = {24'h0, w_byte};
            end
            F3_LH: begin
                bad   = addr_lo[0];
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                ldata = {{16{w_half[15]}}, w_half};
            end
            F3_LHU: begin
                bad   = addr_lo[0];
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                ldata = {16'h0, w_half};
            end
            F3_LW: begin
                bad   = |addr_lo;
                be    = 4'b1111;
                ldata = rword;
            end
            default: bad = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage data memory with valid/ready request and response
//               handshakes, programmable wait latency and RV32I lane rules.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LAT         = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_f3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic        DIRECT = (LAT == 0);
    localparam logic [3:0]  LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    dmem_state_t r_state, w_next;
    dmem_req_t   r_req, w_in, w_cur;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept, w_to_resp, w_commit, w_hi_bad, w_lane_bad, w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword, w_wword, w_ldata;
    logic [3:0]       w_be;

    assign w_in = '{read: req_read, write: req_write, addr: req_addr,
                    wdata: req_wdata, f3: req_f3};

    // With LAT=0 the access happens on the accepting edge, before r_req is loaded.
    assign w_cur    = (r_state == IDLE) ? w_in : r_req;
    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_idx    = w_cur.addr[IDX_W+1:2];
    assign w_rword  = r_mem[w_idx];

    generate
        if (IDX_W + 2 < 32) begin : g_hi_chk
            assign w_hi_bad = |w_cur.addr[31:IDX_W+2];
        end else begin : g_no_hi
            assign w_hi_bad = 1'b0;
        end
    endgenerate

    dmem_lane_align u_lane (
        .f3      (w_cur.f3),
        .addr_lo (w_cur.addr[1:0]),
        .wdata   (w_cur.wdata),
        .rword   (w_rword),
        .be      (w_be),
        .wword   (w_wword),
        .ldata   (w_ldata),
        .bad     (w_lane_bad)
    );

    assign w_err = (w_cur.read == w_cur.write) || w_lane_bad || w_hi_bad
                   || (w_cur.write && w_cur.f3[2]);

    // rst_n gate keeps a LAT=0 request held across reset from writing the array.
    assign w_commit = w_to_resp && w_cur.write && !w_err && rst_n;

    always_comb begin
        w_next    = r_state;
        w_to_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (DIRECT) begin
                        w_next    = RESP;
                        w_to_resp = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next    = RESP;
                    w_to_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= '0;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req <= w_in;
                r_cnt <= LAT_M1;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_to_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_cur.read && !w_err) ? w_ldata : 32'h0;
            end else if (r_state == RESP && rsp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed scoreboard bench for dmem_responder at LAT=1, 3, 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid, rsp_ready;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_f3;
    logic [2:0]  req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata [3];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   prev_acc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(1024), .LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_f3(req_f3), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_responder #(.DEPTH_WORDS(1024), .LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_f3(req_f3), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    dmem_responder #(.DEPTH_WORDS(1024), .LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_f3(req_f3), .rsp_valid(rsp_valid[2]),
        .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : (u == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int u);
        chk("rst_req_ready", 32'(req_ready[u]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[u], 32'h0);
        chk("rst_rsp_err",   32'(rsp_err[u]), 32'd0);
    endtask

    // One request/response; hold = cycles of rsp_ready backpressure in RESP.
    task automatic xact(input int u, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] er, input logic ee, input int hold, input bit b2b);
        exp_t e;
        int   k;
        int   acc;
        e.rdata = er;
        e.err   = ee;
        sb_q.push_back(e);
        @(negedge clk);
        k = 0;
        while (req_ready[u] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk("req_ready_idle", 32'(req_ready[u]), 32'd1);
        req_read = rd; req_write = wr; req_addr = a; req_wdata = wd; req_f3 = f3;
        req_valid[u] = 1'b1;
        rsp_ready[u] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        if (b2b) chk("accept_gap", 32'(acc - prev_acc), 32'd2);
        prev_acc = acc;
        req_valid[u] = 1'b0;
        req_read  = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_f3    = 3'($urandom);
        chk("req_ready_busy", 32'(req_ready[u]), 32'd0);
        k = 0;
        while (rsp_valid[u] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk("latency", 32'(k), 32'(lat_of(u)));
        e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid[u]), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata[u], e.rdata);
            chk("bp_rsp_err",   32'(rsp_err[u]), 32'(e.err));
            chk("bp_req_ready", 32'(req_ready[u]), 32'd0);
            @(negedge clk);
        end
        chk("rsp_rdata", rsp_rdata[u], e.rdata);
        chk("rsp_err",   32'(rsp_err[u]), 32'(e.err));
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_done", 32'(rsp_valid[u]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0; req_valid = 3'b000; rsp_ready = 3'b111;
        req_read = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_f3 = 3'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) chk_reset(u);
        rst_n = 1'b1;

        // LAT=1: store, lane updates, extensions
        xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        xact(0, 1'b0, 1'b1, 32'h11, 32'h000000AA, 3'b000, 32'h0,        1'b0, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADAAEF, 1'b0, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h11, 32'h0,        3'b000, 32'hFFFFFFAA, 1'b0, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h11, 32'h0,        3'b100, 32'h000000AA, 1'b0, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 1'b0, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 0, 1'b0);

        // illegal requests must not disturb the array
        xact(0, 1'b1, 1'b0, 32'h13, 32'h0,        3'b010, 32'h0, 1'b1, 0, 1'b0);
        xact(0, 1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 3'b001, 32'h0, 1'b1, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b011, 32'h0, 1'b1, 0, 1'b0);
        xact(0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1, 0, 1'b0);
        xact(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h0, 1'b1, 0, 1'b0);
        xact(0, 1'b0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h0, 1'b1, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADAAEF, 1'b0, 0, 1'b0);
        xact(0, 1'b0, 1'b1, 32'h12, 32'hBEEF1234, 3'b001, 32'h0,        1'b0, 0, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'h1234AAEF, 1'b0, 0, 1'b0);

        // reset during WAIT drops the store
        xact(0, 1'b0, 1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        req_read = 1'b0; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_f3 = 3'b010; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("wait_req_ready", 32'(req_ready[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk_reset(0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, 0, 1'b0);

        // LAT=3 with backpressure
        xact(1, 1'b0, 1'b1, 32'h10, 32'hA5A55A5A, 3'b010, 32'h0,        1'b0, 0, 1'b0);
        xact(1, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hA5A55A5A, 1'b0, 5, 1'b0);
        xact(1, 1'b1, 1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFFA5A5, 1'b0, 2, 1'b0);
        xact(1, 1'b1, 1'b0, 32'h11, 32'h0,        3'b101, 32'h0,        1'b1, 3, 1'b0);

        // LAT=0 back-to-back, out-of-range addresses
        xact(2, 1'b0, 1'b1, 32'h40,   32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 0, 1'b0);
        xact(2, 1'b1, 1'b0, 32'h40,   32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 0, 1'b1);
        xact(2, 1'b1, 1'b0, 32'h42,   32'h0,        3'b101, 32'h0000CAFE, 1'b0, 0, 1'b1);
        xact(2, 1'b1, 1'b0, 32'h43,   32'h0,        3'b000, 32'hFFFFFFCA, 1'b0, 0, 1'b1);
        xact(2, 1'b1, 1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1, 0, 1'b1);
        xact(2, 1'b0, 1'b1, 32'h1040, 32'h11111111, 3'b010, 32'h0,        1'b1, 0, 1'b1);
        xact(2, 1'b1, 1'b0, 32'h40,   32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 0, 1'b1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
